prog_timeout_counter: RTL and testbench

//  Generalised timeout counter: counts single-cycle tick_in strobes (e.g. a 1 ms strobe) up to a

---
 rtl/timer_pkg.sv | 13 +
 rtl/prog_timeout_counter.sv | 120 ++++++++++++
 tb/tb_prog_timeout_counter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared timer definitions: FSM state encoding and mode constants used by the
// timeout counter and the other timer blocks.
package timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage : timer_pkg

// File: rtl/prog_timeout_counter.sv
// Programmable timeout counter: counts tick_in strobes up to a terminal count
// latched at start and emits a one-cycle timeout pulse (one-shot or periodic).
module prog_timeout_counter
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W        = 7,
    parameter bit          PERIODIC_RST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] terminal,
    output logic [CNT_W-1:0] count,
    output logic             timeout,
    output logic             busy,
    output logic             err
);

    localparam int unsigned CMP_W = CNT_W + 1;

    timer_state_t     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] term_q,  term_d;
    logic             mode_q,  mode_d;
    logic             timeout_q, timeout_d;
    logic             err_q,   err_d;
    logic             busy_q;
    logic [CMP_W-1:0] cnt_inc;
    logic             term_hit;

    // Compare one bit wider than the counter so count+1 can never alias to zero
    assign cnt_inc  = CMP_W'(count_q) + CMP_W'(1);
    assign term_hit = (cnt_inc == CMP_W'(term_q));

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        term_d    = term_q;
        mode_d    = mode_q;
        timeout_d = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (terminal != '0) begin
                        term_d  = terminal;
                        mode_d  = mode;
                        count_d = '0;
                        state_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    // A coincident tick is dropped; a zero terminal keeps the old period running
                    if (terminal != '0) begin
                        term_d  = terminal;
                        mode_d  = mode;
                        count_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (tick_in) begin
                    if (term_hit) begin
                        timeout_d = 1'b1;
                        if (mode_q == MODE_PERIODIC) begin
                            count_d = '0;
                        end else begin
                            count_d = term_q;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        count_d = cnt_inc[CNT_W-1:0];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            term_q    <= '0;
            mode_q    <= PERIODIC_RST;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            term_q    <= term_d;
            mode_q    <= mode_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            busy_q    <= (state_d == ST_RUN);
        end
    end

    assign count   = count_q;
    assign timeout = timeout_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule : prog_timeout_counter

// File: tb/tb_prog_timeout_counter.sv
// Directed bench for prog_timeout_counter: one task per scenario with inline
// checks against hand-computed values.
module tb_prog_timeout_counter;

    localparam int unsigned CNT_W = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick_in;
    logic             start;
    logic             stop;
    logic             mode;
    logic [CNT_W-1:0] terminal;
    logic [CNT_W-1:0] count;
    logic             timeout;
    logic             busy;
    logic             err;

    int checks = 0;
    int errors = 0;

    prog_timeout_counter #(.CNT_W(CNT_W), .PERIODIC_RST(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_in  (tick_in),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .terminal (terminal),
        .count    (count),
        .timeout  (timeout),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Apply one cycle of control inputs; returns 1 time unit after the sampling edge
    task automatic step(input logic t, input logic s, input logic p);
        @(negedge clk);
        tick_in = t;
        start   = s;
        stop    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick_in = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; terminal = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (count !== 7'd0 || timeout !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: count=%0d timeout=%b busy=%b err=%b required 0 0 0 0",
                     count, timeout, busy, err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_oneshot_100();
        int bad = 0;
        terminal = 7'd100; mode = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (busy !== 1'b1 || count !== 7'd0) begin
            errors++;
            $display("FAIL oneshot_start: busy=%b count=%0d required 1 0", busy, count);
        end
        terminal = 7'd5;  // must not affect the running period
        for (int i = 1; i <= 100; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i < 100) begin
                if (timeout !== 1'b0 || count !== 7'(i) || busy !== 1'b1) bad++;
                for (int j = 0; j < 3; j++) begin
                    step(1'b0, 1'b0, 1'b0);
                    if (timeout !== 1'b0 || count !== 7'(i)) bad++;
                end
            end
        end
        checks++;
        if (timeout !== 1'b1 || count !== 7'd100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_timeout: timeout=%b count=%0d busy=%b required 1 100 0",
                     timeout, count, busy);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL oneshot_progress: %0d bad cycles required 0", bad);
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (timeout !== 1'b0 || count !== 7'd100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_after: timeout=%b count=%0d busy=%b required 0 100 0",
                     timeout, count, busy);
        end
    endtask

    task automatic test_periodic_3();
        terminal = 7'd3; mode = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        mode = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (count !== 7'(k % 3) || timeout !== (k % 3 == 0) || busy !== 1'b1) begin
                errors++;
                $display("FAIL periodic_k%0d: count=%0d timeout=%b busy=%b required %0d %b 1",
                         k, count, timeout, busy, k % 3, (k % 3 == 0));
            end
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b0 || count !== 7'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL periodic_stop: busy=%b count=%0d timeout=%b required 0 0 0",
                     busy, count, timeout);
        end
    endtask

    task automatic test_terminal_one();
        terminal = 7'd1; mode = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (timeout !== 1'b1 || count !== 7'd0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL term1_k%0d: timeout=%b count=%0d busy=%b required 1 0 1",
                         k, timeout, count, busy);
            end
        end
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_stop();
        terminal = 7'd10; mode = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (count !== 7'd5) begin
            errors++;
            $display("FAIL stop_pre: count=%0d required 5", count);
        end
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (timeout !== 1'b0 || count !== 7'd5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_tick: timeout=%b count=%0d busy=%b required 0 5 0",
                     timeout, count, busy);
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (timeout !== 1'b0 || count !== 7'd5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle_tick: timeout=%b count=%0d busy=%b required 0 5 0",
                     timeout, count, busy);
        end
    endtask

    task automatic test_err();
        terminal = 7'd0; mode = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || count !== 7'd5) begin
            errors++;
            $display("FAIL err_idle: err=%b busy=%b count=%0d required 1 0 5", err, busy, count);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_idle_pulse: err=%b busy=%b required 0 0", err, busy);
        end
        terminal = 7'd4;
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        terminal = 7'd0;
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (err !== 1'b1 || busy !== 1'b1 || count !== 7'd2) begin
            errors++;
            $display("FAIL err_run: err=%b busy=%b count=%0d required 1 1 2", err, busy, count);
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b0 || count !== 7'd3 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL err_run_next: err=%b count=%0d timeout=%b required 0 3 0",
                     err, count, timeout);
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (timeout !== 1'b1 || count !== 7'd4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_old_term: timeout=%b count=%0d busy=%b required 1 4 0",
                     timeout, count, busy);
        end
    endtask

    task automatic test_restart();
        int bad = 0;
        terminal = 7'd50; mode = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        repeat (7) step(1'b1, 1'b0, 1'b0);
        terminal = 7'd20; mode = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (count !== 7'd0 || timeout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart: count=%0d timeout=%b busy=%b required 0 0 1",
                     count, timeout, busy);
        end
        for (int i = 1; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (count !== 7'(i) || timeout !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL restart_progress: %0d bad cycles required 0", bad);
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (timeout !== 1'b1 || count !== 7'd20 || busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_timeout: timeout=%b count=%0d busy=%b required 1 20 0",
                     timeout, count, busy);
        end
    endtask

    task automatic test_rst_midrun_and_max();
        int bad = 0;
        terminal = 7'd127; mode = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        repeat (50) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (count !== 7'd50 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: count=%0d busy=%b required 50 1", count, busy);
        end
        @(negedge clk);
        tick_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (count !== 7'd0 || busy !== 1'b0 || timeout !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: count=%0d busy=%b timeout=%b err=%b required 0 0 0 0",
                     count, busy, timeout, err);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 127; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (count !== 7'(i) || timeout !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL max_progress: %0d bad cycles required 0", bad);
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (timeout !== 1'b1 || count !== 7'd127 || busy !== 1'b0) begin
            errors++;
            $display("FAIL max_timeout: timeout=%b count=%0d busy=%b required 1 127 0",
                     timeout, count, busy);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot_100();
        test_periodic_3();
        test_terminal_one();
        test_stop();
        test_err();
        test_restart();
        test_rst_midrun_and_max();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_prog_timeout_counter
